// File: rtl/rnn_accelerator_if.sv
// Host register bus for the RNN accelerator: strobes, 3-bit select, 32-bit write data, status/result readback.
interface rnn_accelerator_if;
   logic        read;
   logic        write;
   logic [2:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;

   modport master (output read, write, addr, data_in, input data_out);
   modport slave  (input read, write, addr, data_in, output data_out);
endinterface

// File: rtl/rnn_accelerator.sv
// SimpleRNN (4-in, 32 hidden) plus 32-to-1 dense head in Q8.8; recurrent step ~1027 cycles, dense step 33 cycles.
// Configuration and commands are accepted only while idle in LOAD; the host polls data_out bit 16 for the result.
module rnn_accelerator #(
   parameter int IN_DIM  = 4,
   parameter int HID_DIM = 32,
   parameter int DW      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   rnn_accelerator_if.slave bus
);
   localparam int XW = $clog2(IN_DIM);
   localparam int HW = $clog2(HID_DIM);
   localparam int AW = 40;
   localparam int PW = 2 * DW;
   localparam logic signed [AW-1:0] SAT_HI = (AW'(1) <<< (DW - 1)) - AW'(1);
   localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - AW'(1);
   localparam logic signed [DW-1:0] ONE    = DW'(256);

   typedef enum logic [2:0] {
      S_LOAD, S_START, S_MULT, S_UPDATE, S_DENSE, S_VALID, S_CLEAR
   } state_t;

   function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] s);
      logic signed [AW-1:0] t;
      t = s >>> 8;
      if (t > SAT_HI)      sat_dw = SAT_HI[DW-1:0];
      else if (t < SAT_LO) sat_dw = SAT_LO[DW-1:0];
      else                 sat_dw = t[DW-1:0];
   endfunction

   function automatic logic signed [DW-1:0] hardtanh(input logic signed [DW-1:0] v);
      if (v > ONE)       hardtanh = ONE;
      else if (v < -ONE) hardtanh = -ONE;
      else               hardtanh = v;
   endfunction

   // Biases are Q8.8 but products are Q16.16, so shift up before summing.
   function automatic logic signed [AW-1:0] q_align(input logic signed [DW-1:0] b);
      q_align = {{(AW-DW-8){b[DW-1]}}, b, 8'd0};
   endfunction

   function automatic logic signed [AW-1:0] p_ext(input logic signed [PW-1:0] p);
      p_ext = {{(AW-PW){p[PW-1]}}, p};
   endfunction

   state_t state_q, state_d;

   logic signed [DW-1:0] x_q [IN_DIM];
   logic signed [DW-1:0] w_q [IN_DIM][HID_DIM];
   logic signed [DW-1:0] r_q [HID_DIM][HID_DIM];
   logic signed [DW-1:0] b_q [HID_DIM];
   logic signed [DW-1:0] d_q [HID_DIM];
   logic signed [DW-1:0] h_q [HID_DIM];
   logic signed [DW-1:0] h_new [HID_DIM];
   logic signed [DW-1:0] db_q;
   logic signed [DW-1:0] res_q, res_d;

   logic signed [AW-1:0] w_acc_q [HID_DIM];
   logic signed [AW-1:0] r_acc_q [HID_DIM];
   logic signed [AW-1:0] w_acc_d, r_acc_d, d_acc_q, d_acc_d;
   logic signed [PW-1:0] w_prod, r_prod, d_prod;

   logic [XW+HW-1:0] w_cnt_q, w_cnt_d;
   logic [2*HW-1:0]  r_cnt_q, r_cnt_d;
   logic [HW:0]      d_cnt_q, d_cnt_d;
   logic             w_busy_q, w_busy_d, w_rdy_q, w_rdy_d, w_seen_q, w_seen_d;
   logic             r_busy_q, r_busy_d, r_rdy_q, r_rdy_d, r_seen_q, r_seen_d;
   logic             w_done, r_done;

   logic [XW-1:0]        w_i;
   logic [HW-1:0]        w_j, r_j, r_k, d_idx;
   logic [15:0]          wr_idx;
   logic [7:0]           wr_row, wr_col;
   logic signed [DW-1:0] wr_val;

   logic cfg_we, step_go, dense_go, x_we, w_we, r_we, b_we, d_we, db_we;
   logic mac_start, h_upd, h_clr, valid, dense_run;

   assign wr_idx = bus.data_in[31:16];
   assign wr_row = bus.data_in[31:24];
   assign wr_col = bus.data_in[23:16];
   assign wr_val = bus.data_in[DW-1:0];

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_LOAD;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:   if (step_go) state_d = S_START;
                   else if (dense_go) state_d = S_DENSE;
         S_START:  state_d = S_MULT;
         S_MULT:   if (w_done && r_done) state_d = S_UPDATE;
         S_UPDATE: state_d = S_LOAD;
         S_DENSE:  if (d_cnt_q[HW]) state_d = S_VALID;
         S_VALID:  if (bus.read) state_d = S_CLEAR;
         S_CLEAR:  state_d = S_LOAD;
         default:  state_d = S_LOAD;
      endcase
   end

   // FSM: outputs and register-write decode
   always_comb begin
      cfg_we    = bus.write && (state_q == S_LOAD);
      mac_start = (state_q == S_START);
      h_upd     = (state_q == S_UPDATE);
      h_clr     = (state_q == S_CLEAR);
      valid     = (state_q == S_VALID);
      dense_run = (state_q == S_DENSE);
      step_go   = cfg_we && (bus.addr == 3'd0);
      x_we      = cfg_we && (bus.addr == 3'd1) && (wr_idx < 16'(IN_DIM));
      w_we      = cfg_we && (bus.addr == 3'd2) && (wr_row < 8'(IN_DIM)) && (wr_col < 8'(HID_DIM));
      r_we      = cfg_we && (bus.addr == 3'd3) && (wr_row < 8'(HID_DIM)) && (wr_col < 8'(HID_DIM));
      b_we      = cfg_we && (bus.addr == 3'd4) && (wr_idx < 16'(HID_DIM));
      d_we      = cfg_we && (bus.addr == 3'd5) && (wr_idx < 16'(HID_DIM));
      db_we     = cfg_we && (bus.addr == 3'd6);
      dense_go  = cfg_we && (bus.addr == 3'd7);
   end

   // Input MAC walks j-major so each hidden unit's sum finishes before moving on.
   assign w_j    = w_cnt_q[XW+HW-1:XW];
   assign w_i    = w_cnt_q[XW-1:0];
   assign r_j    = r_cnt_q[2*HW-1:HW];
   assign r_k    = r_cnt_q[HW-1:0];
   assign d_idx  = d_cnt_q[HW-1:0];
   assign w_done = w_seen_q | w_rdy_q;
   assign r_done = r_seen_q | r_rdy_q;

   always_comb begin
      w_prod  = PW'(x_q[w_i]) * PW'(w_q[w_i][w_j]);
      r_prod  = PW'(h_q[r_k]) * PW'(r_q[r_k][r_j]);
      d_prod  = PW'(h_q[d_idx]) * PW'(d_q[d_idx]);
      w_acc_d = w_acc_q[w_j] + p_ext(w_prod);
      r_acc_d = r_acc_q[r_j] + p_ext(r_prod);

      w_cnt_d  = w_cnt_q;
      w_busy_d = w_busy_q;
      w_rdy_d  = 1'b0;
      w_seen_d = w_seen_q | w_rdy_q;
      if (mac_start) begin
         w_cnt_d  = '0;
         w_busy_d = 1'b1;
         w_seen_d = 1'b0;
      end else if (w_busy_q) begin
         w_cnt_d = w_cnt_q + 1'b1;
         if (&w_cnt_q) begin
            w_busy_d = 1'b0;
            w_rdy_d  = 1'b1;
         end
      end

      r_cnt_d  = r_cnt_q;
      r_busy_d = r_busy_q;
      r_rdy_d  = 1'b0;
      r_seen_d = r_seen_q | r_rdy_q;
      if (mac_start) begin
         r_cnt_d  = '0;
         r_busy_d = 1'b1;
         r_seen_d = 1'b0;
      end else if (r_busy_q) begin
         r_cnt_d = r_cnt_q + 1'b1;
         if (&r_cnt_q) begin
            r_busy_d = 1'b0;
            r_rdy_d  = 1'b1;
         end
      end

      d_acc_d = d_acc_q;
      d_cnt_d = d_cnt_q;
      res_d   = res_q;
      if (dense_go) begin
         d_acc_d = '0;
         d_cnt_d = '0;
         res_d   = '0;
      end else if (dense_run) begin
         if (!d_cnt_q[HW]) begin
            d_acc_d = d_acc_q + p_ext(d_prod);
            d_cnt_d = d_cnt_q + 1'b1;
         end else begin
            res_d = sat_dw(d_acc_q + q_align(db_q));
         end
      end
   end

   always_comb begin
      for (int j = 0; j < HID_DIM; j++)
         h_new[j] = hardtanh(sat_dw(w_acc_q[j] + r_acc_q[j] + q_align(b_q[j])));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_cnt_q  <= '0;
         r_cnt_q  <= '0;
         d_cnt_q  <= '0;
         w_busy_q <= 1'b0;
         w_rdy_q  <= 1'b0;
         w_seen_q <= 1'b0;
         r_busy_q <= 1'b0;
         r_rdy_q  <= 1'b0;
         r_seen_q <= 1'b0;
         d_acc_q  <= '0;
         res_q    <= '0;
         db_q     <= '0;
      end else begin
         w_cnt_q  <= w_cnt_d;
         r_cnt_q  <= r_cnt_d;
         d_cnt_q  <= d_cnt_d;
         w_busy_q <= w_busy_d;
         w_rdy_q  <= w_rdy_d;
         w_seen_q <= w_seen_d;
         r_busy_q <= r_busy_d;
         r_rdy_q  <= r_rdy_d;
         r_seen_q <= r_seen_d;
         d_acc_q  <= d_acc_d;
         res_q    <= res_d;
         if (db_we) db_q <= wr_val;
      end
   end

   for (genvar i = 0; i < IN_DIM; i++) begin : g_x
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                                  x_q[i] <= '0;
         else if (x_we && wr_idx[XW-1:0] == XW'(i)) x_q[i] <= wr_val;
      end
   end

   for (genvar j = 0; j < HID_DIM; j++) begin : g_hid
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            b_q[j]     <= '0;
            d_q[j]     <= '0;
            h_q[j]     <= '0;
            w_acc_q[j] <= '0;
            r_acc_q[j] <= '0;
         end else begin
            if (b_we && wr_idx[HW-1:0] == HW'(j)) b_q[j] <= wr_val;
            if (d_we && wr_idx[HW-1:0] == HW'(j)) d_q[j] <= wr_val;
            // Whole vector commits at once so every unit saw the previous h.
            if (h_clr)      h_q[j] <= '0;
            else if (h_upd) h_q[j] <= h_new[j];
            if (mac_start)                       w_acc_q[j] <= '0;
            else if (w_busy_q && w_j == HW'(j)) w_acc_q[j] <= w_acc_d;
            if (mac_start)                       r_acc_q[j] <= '0;
            else if (r_busy_q && r_j == HW'(j)) r_acc_q[j] <= r_acc_d;
         end
      end

      for (genvar i = 0; i < IN_DIM; i++) begin : g_w
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) w_q[i][j] <= '0;
            else if (w_we && wr_row[XW-1:0] == XW'(i) && wr_col[HW-1:0] == HW'(j))
               w_q[i][j] <= wr_val;
         end
      end

      for (genvar k = 0; k < HID_DIM; k++) begin : g_r
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_q[k][j] <= '0;
            else if (r_we && wr_row[HW-1:0] == HW'(k) && wr_col[HW-1:0] == HW'(j))
               r_q[k][j] <= wr_val;
         end
      end
   end

   assign bus.data_out = {{(32-DW-1){1'b0}}, valid, res_q};
endmodule

// File: tb/tb_rnn_accelerator.sv
// Directed bench for rnn_accelerator: table of register writes, then hand-built recurrent/dense sequences.
module tb_rnn_accelerator;
   localparam int ST_LOAD  = 0;
   localparam int ST_START = 1;
   localparam int ST_MULT  = 2;
   localparam int ST_DENSE = 4;
   localparam int ST_VALID = 5;
   localparam int ST_CLEAR = 6;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      int          kind;
      int          i;
      int          j;
      logic [15:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs [13];
   int   wc, rc;

   always #5 clk = ~clk;

   rnn_accelerator_if bus ();
   rnn_accelerator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic logic [15:0] peek(input int kind, input int i, input int j);
      case (kind)
         0:       return dut.x_q[i];
         1:       return dut.w_q[i][j];
         2:       return dut.r_q[i][j];
         3:       return dut.b_q[i];
         4:       return dut.d_q[i];
         5:       return dut.db_q;
         default: return dut.h_q[i];
      endcase
   endfunction

   function automatic int st();
      return int'(dut.state_q);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.write   = 1'b1;
      bus.addr    = a;
      bus.data_in = d;
      @(negedge clk);
      bus.write   = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_state(input int target, input int budget, input string name);
      int n = 0;
      while (st() != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, st(), target);
   endtask

   task automatic run_step(output int w_cyc, output int r_cyc);
      int cyc = 0;
      wr(3'd0, 32'd0);
      check("step_start_state", st(), ST_START);
      w_cyc = 0;
      r_cyc = 0;
      while (st() != ST_LOAD && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (dut.w_rdy_q && w_cyc == 0) w_cyc = cyc;
         if (dut.r_rdy_q && r_cyc == 0) r_cyc = cyc;
      end
      check("step_back_to_load", st(), ST_LOAD);
   endtask

   task automatic check_h(input string name, input logic [15:0] even_exp, input logic [15:0] odd_exp);
      for (int j = 0; j < 32; j++)
         check($sformatf("%s_h%0d", name, j), peek(6, j, 0), (j % 2 == 0) ? even_exp : odd_exp);
   endtask

   initial begin
      bus.read    = 1'b0;
      bus.write   = 1'b0;
      bus.addr    = 3'd0;
      bus.data_in = 32'd0;
      rst_n       = 1'b0;

      vecs[0]  = '{3'd1, 32'h0000_0100, 0, 0,  0,  16'h0100};
      vecs[1]  = '{3'd1, 32'h0001_FF80, 0, 1,  0,  16'hFF80};
      vecs[2]  = '{3'd1, 32'h0002_0040, 0, 2,  0,  16'h0040};
      vecs[3]  = '{3'd1, 32'h0003_7FFF, 0, 3,  0,  16'h7FFF};
      vecs[4]  = '{3'd1, 32'h0009_1234, 0, 1,  0,  16'hFF80};
      vecs[5]  = '{3'd2, 32'h031F_ABCD, 1, 3,  31, 16'hABCD};
      vecs[6]  = '{3'd2, 32'h0400_1111, 1, 0,  0,  16'h0000};
      vecs[7]  = '{3'd3, 32'h1F05_8000, 2, 31, 5,  16'h8000};
      vecs[8]  = '{3'd3, 32'h0020_2222, 2, 0,  0,  16'h0000};
      vecs[9]  = '{3'd4, 32'h0007_0123, 3, 7,  0,  16'h0123};
      vecs[10] = '{3'd4, 32'h0020_4444, 3, 0,  0,  16'h0000};
      vecs[11] = '{3'd5, 32'h001F_FE00, 4, 31, 0,  16'hFE00};
      vecs[12] = '{3'd6, 32'h0000_FF00, 5, 0,  0,  16'hFF00};

      repeat (2) @(negedge clk);
      check("reset_data_out", bus.data_out, 32'h0);
      check("reset_state", st(), ST_LOAD);
      check("reset_x0", peek(0, 0, 0), 16'h0);
      rst_n = 1'b1;

      for (int v = 0; v < 13; v++) begin
         wr(vecs[v].addr, vecs[v].data);
         check($sformatf("vec%0d", v), peek(vecs[v].kind, vecs[v].i, vecs[v].j), vecs[v].exp);
      end

      // Writes are dropped mid-step; reset aborts and zeroes storage.
      wr(3'd0, 32'd0);
      check("abort_start_state", st(), ST_START);
      repeat (10) @(negedge clk);
      check("abort_mult_state", st(), ST_MULT);
      wr(3'd1, 32'h0000_5555);
      check("write_ignored_in_mult", peek(0, 0, 0), 16'h0100);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_state", st(), ST_LOAD);
      check("abort_x0", peek(0, 0, 0), 16'h0);
      check("abort_w", peek(1, 3, 31), 16'h0);
      check("abort_db", peek(5, 0, 0), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // x=[1,0,0,0], W[0][j]=0.5 -> h=0.5
      wr(3'd1, 32'h0000_0100);
      for (int j = 0; j < 32; j++) wr(3'd2, {8'd0, 8'(j), 16'h0080});
      run_step(wc, rc);
      check("w_ready_before_r", (wc > 0) && (wc < rc), 1'b1);
      check("r_ready_after_1024_macs", rc >= 1024, 1'b1);
      check_h("half", 16'h0080, 16'h0080);
      check("step_data_out", bus.data_out, 32'h0);

      // Dense: 32 * 0.5 * 1.0 = 16.0
      for (int j = 0; j < 32; j++) wr(3'd5, {16'(j), 16'h0100});
      @(negedge clk) bus.read = 1'b1;
      @(negedge clk) bus.read = 1'b0;
      check("read_in_load_state", st(), ST_LOAD);
      check("read_in_load_h", peek(6, 5, 0), 16'h0080);
      wr(3'd7, 32'd0);
      check("dense_state", st(), ST_DENSE);
      check("dense_entry_result", bus.data_out, 32'h0);
      wait_state(ST_VALID, 100, "dense_reach_valid");
      check("dense_result", bus.data_out, 32'h0001_1000);

      // read and write together in VALID: read wins
      @(negedge clk);
      bus.read = 1'b1; bus.write = 1'b1; bus.addr = 3'd6; bus.data_in = 32'h0000_FF00;
      @(negedge clk);
      bus.read = 1'b0; bus.write = 1'b0;
      check("clear_state", st(), ST_CLEAR);
      check("clear_data_out", bus.data_out, 32'h0000_1000);
      check("clear_write_dropped", peek(5, 0, 0), 16'h0);
      @(negedge clk);
      check("after_clear_state", st(), ST_LOAD);
      check_h("cleared", 16'h0, 16'h0);

      // h=0 so the logit is just the bias (-1.0)
      wr(3'd6, 32'h0000_FF00);
      check("db_written", peek(5, 0, 0), 16'hFF00);
      wr(3'd7, 32'd0);
      check("dense2_state", st(), ST_DENSE);
      check("dense2_entry_result", bus.data_out, 32'h0);
      wait_state(ST_VALID, 100, "dense2_reach_valid");
      check("dense2_result", bus.data_out, 32'h0001_FF00);
      @(negedge clk) bus.read = 1'b1;
      @(negedge clk) bus.read = 1'b0;
      wait_state(ST_LOAD, 5, "dense2_release");

      // x=8.0, W=+/-8.0 -> pre-activation +/-64.0, clamped to +/-1.0
      pulse_reset();
      wr(3'd1, 32'h0000_0800);
      for (int j = 0; j < 32; j++) wr(3'd2, {8'd0, 8'(j), (j % 2 == 0) ? 16'h0800 : 16'hF800});
      run_step(wc, rc);
      check_h("sat", 16'h0100, 16'hFF00);

      // Bias then recurrence: step1 h=0.75, step2 h0=0.75+24/256, h1=0.75-24/256
      pulse_reset();
      wr(3'd1, 32'h0000_0100);
      for (int j = 0; j < 32; j++) begin
         wr(3'd2, {8'd0, 8'(j), 16'h0080});
         wr(3'd4, {16'(j), 16'h0040});
      end
      run_step(wc, rc);
      check_h("bias", 16'h00C0, 16'h00C0);
      for (int k = 0; k < 32; k++) begin
         wr(3'd3, {8'(k), 8'd0, 16'h0001});
         wr(3'd3, {8'(k), 8'd1, 16'hFFFF});
      end
      run_step(wc, rc);
      check("rec_h0", peek(6, 0, 0), 16'h00D8);
      check("rec_h1", peek(6, 1, 0), 16'h00A8);
      check("rec_h2", peek(6, 2, 0), 16'h00C0);
      check("rec_h31", peek(6, 31, 0), 16'h00C0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rnn_accelerator.md
Name: rnn_accelerator

Overview:
- Memory-mapped single-layer RNN inference accelerator (SimpleRNN, 4-element input embedding, 32 hidden units) with a 32-to-1 dense output layer.
- Host writes weights, biases and one character embedding per timestep through a 3-bit address bus.
- Host triggers one recurrent step per character, then the dense step, and reads a signed 16-bit logit.
- Sits behind a simple bus slave bridge (read/write/addr/data).

Parameters:
- IN_DIM, 4, input embedding length.
- HID_DIM, 32, hidden state length.
- DW, 16, data width: signed Q8.8 fixed point.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read  input  1  read strobe; in VALID it acknowledges the result and clears the hidden state.
- write  input  1  write strobe, qualified by addr.
- addr  input  3  register/command select.
- data_in  input  32  write data.
- data_out  output  32  bits[15:0] = result, bit 16 = valid (state==VALID), bits[31:17] = 0.

Behaviour:
- Reset (async, rst_n=0): all storage zero (x, W, R, rnn bias, hidden, dense weights, dense bias, result). State = LOAD, data_out = 0.
- Writes are registered on the rising edge. Register and command writes take effect only in state LOAD; writes in other states are ignored.
- addr 0: start one recurrent step (LOAD->START).
- addr 1: x[data_in[31:16]] <= data_in[15:0], index 0..3.
- addr 2: W[data_in[31:24]][data_in[23:16]] <= data_in[15:0]; W is 4x32.
- addr 3: R[row][col] <= data_in[15:0], same field layout; R is 32x32.
- addr 4: rnn_bias[data_in[31:16]] <= data_in[15:0], index 0..31.
- addr 5: dense weight D[data_in[31:16]] <= data_in[15:0], index 0..31.
- addr 6: dense_bias <= data_in[15:0].
- addr 7: start dense step (LOAD->DENSE).
- Out-of-range indices are ignored with no state change.
- Arithmetic:
  - Q8.8 multiply gives a 32-bit product; accumulate in a 40-bit signed accumulator.
  - Final sum >>> 8, then saturate to the 16-bit range [-32768, 32767].
- Recurrent step: h_new[j] = hardtanh(sum_i x[i]*W[i][j] + sum_k h[k]*R[k][j] + rnn_bias[j]).
  - hardtanh clamps to [-256, +256], i.e. ±1.0.
  - Every h_new uses the old h; h is committed all at once.
- Dense step: result = sat16(sum_k h[k]*D[k] + dense_bias). No activation; the result is a signed logit.
- Multipliers: two sequential single-MAC units, one MAC per cycle, both started together in START.
  - weight_multiplier: 128 cycles.
  - recurrent_multiplier: 1024 cycles.
  - Each has a `ready` output that pulses high for one cycle when its 32-element result vector is complete.
- State machine:
  - LOAD: idle. write addr0 -> START; write addr7 -> DENSE.
  - START: one cycle; clears accumulators and launches both multipliers -> MULT.
  - MULT: wait until both ready flags have been seen -> UPDATE.
  - UPDATE: one cycle; add rnn_bias, apply hardtanh, write hidden -> LOAD. Total step ≈ 1027 cycles.
  - DENSE: result cleared to 0 on entry; 32 MAC cycles plus bias add -> VALID.
  - VALID: result held, valid=1. read=1 -> CLEAR; other writes ignored.
  - CLEAR: one cycle; hidden vector zeroed; result retained; valid=0 -> LOAD.
- Simultaneous read and write in VALID: read wins and the write is dropped.
- Reset mid-operation: abort to LOAD with all storage zeroed.
- read outside VALID: no effect; data_out reflects the current result and valid=0.

Test Plan:
- Write addr1 with {i,E[c][i]} for i=0..3 -> x[i] equals E[c][i] at the next falling edge. Write {9,16'h1234} -> no change.
- Load W (4x32), R (32x32), rnn_bias, D (32) and dense_bias=16'hFF00 (-1.0) via addr 2..6 -> every storage element matches its written value one cycle after its write.
- Write addr0 -> state=START the next cycle. weight_multiplier.ready pulses before recurrent_multiplier.ready. State returns to LOAD. With x=[256,0,0,0], W[0][j]=128, R=0, bias=0 -> h[j]=128.
- Drive h to ±saturation with large weights (x=W=256*8) -> h[j]=256 exactly, not larger.
- Write addr7 -> DENSE with result=0, then VALID. With h[j]=128, D[j]=256, bias 0 -> result=4096 and data_out=32'h0001_1000.
- In VALID assert read -> CLEAR, then LOAD with all h=0. Write addr7 -> result=0 in DENSE, then result=dense_bias=-256 (<0) in VALID.
